// File: rtl/ym_audio_pkg.sv
// ym_audio_pkg: shared types, word constants and the float-to-PCM decode for the YM serial audio link
package ym_audio_pkg;
  typedef enum logic [1:0] {HUNT, SYNC, GOT_L} rx_state_e;
  localparam int WORD_BITS = 13;
  localparam int MANT_BITS = 10;
  localparam int EXP_BITS  = 3;
  localparam int PCM_WIDTH = 16;
  function automatic logic signed [PCM_WIDTH-1:0] ym_fp_to_pcm(input logic [WORD_BITS-1:0] w);
    logic [EXP_BITS-1:0] e;
    logic signed [PCM_WIDTH-1:0] s;
    e = w[WORD_BITS-1:MANT_BITS];
    // offset-binary mantissa: flipping the top bit yields a signed value, then sign-extend
    s = {{(PCM_WIDTH-MANT_BITS+1){~w[MANT_BITS-1]}}, w[MANT_BITS-2:0]};
    return (e == '0) ? '0 : s <<< (e - 3'd1);
  endfunction
endpackage

// File: rtl/ym_sync_edge.sv
// ym_sync_edge: multi-flop input synchronizer with single-cycle rise/fall event pulses
module ym_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic prev;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev   <= sync_q[SYNC_STAGES-1];
    end
  end
  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/ym3012_rx.sv
// ym3012_rx: YM2151-style serial DAC link receiver producing signed 16-bit stereo PCM pairs
module ym3012_rx import ym_audio_pkg::*; #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        so_clk,
  input  logic                        so,
  input  logic                        sh1,
  input  logic                        sh2,
  output logic signed [PCM_WIDTH-1:0] pcm_l,
  output logic signed [PCM_WIDTH-1:0] pcm_r,
  output logic                        pcm_valid,
  input  logic                        pcm_ready,
  output logic                        overrun,
  output logic                        locked
);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [3:0] pins, q, rise, fall;
  logic unused_ev;
  logic so_rise, f1, f2, full, timeout, clr, ld_l, pub;
  logic [WORD_BITS-1:0] sr;
  logic [3:0] cnt;
  logic [TW-1:0] to_cnt;
  logic signed [PCM_WIDTH-1:0] hold_l;
  rx_state_e state, nxt;
  assign pins = {sh2, sh1, so, so_clk};
  genvar i;
  for (i = 0; i < 4; i++) begin : g_sync
    ym_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .d(pins[i]),
      .q(q[i]), .rise(rise[i]), .fall(fall[i])
    );
  end
  assign unused_ev = ^{q[3:2], q[0], rise[3:1], fall[1:0]};
  assign so_rise = rise[0];
  assign f1      = fall[2];
  assign f2      = fall[3];
  assign full    = cnt == 4'(WORD_BITS);
  assign timeout = to_cnt == TW'(TIMEOUT);
  always_comb begin
    nxt  = state;
    clr  = 1'b0;
    ld_l = 1'b0;
    pub  = 1'b0;
    if (timeout) nxt = HUNT;
    else if (f1 | f2) begin
      clr = 1'b1;
      nxt = SYNC;
      // simultaneous strobes are a protocol error and fall through to SYNC
      if (!(f1 & f2) && full) begin
        if (f1 && state != HUNT) begin
          ld_l = 1'b1;
          nxt  = GOT_L;
        end
        if (f2 && state == GOT_L) pub = 1'b1;
      end
    end
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= HUNT;
      sr        <= '0;
      cnt       <= '0;
      to_cnt    <= '0;
      hold_l    <= '0;
      pcm_l     <= '0;
      pcm_r     <= '0;
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state <= nxt;
      // strobes see the pre-shift word; a coincident bit then starts the next word
      if (so_rise) sr <= {q[1], sr[WORD_BITS-1:1]};
      if (so_rise) cnt <= clr ? 4'd1 : (full ? cnt : cnt + 4'd1);
      else if (clr) cnt <= '0;
      to_cnt <= so_rise ? '0 : (timeout ? to_cnt : to_cnt + TW'(1));
      if (ld_l) hold_l <= ym_fp_to_pcm(sr);
      if (timeout) locked <= 1'b0;
      else if (pub) locked <= 1'b1;
      if (pub && (!pcm_valid || pcm_ready)) begin
        pcm_l     <= hold_l;
        pcm_r     <= ym_fp_to_pcm(sr);
        pcm_valid <= 1'b1;
      end else if (pub) overrun <= 1'b1;
      else if (pcm_valid && pcm_ready) pcm_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ym3012_rx.sv
// tb_ym3012_rx: directed test of the serial link receiver with hand-computed PCM values
module tb_ym3012_rx;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic so_clk = 1'b0;
  logic so = 1'b0;
  logic sh1 = 1'b1;
  logic sh2 = 1'b1;
  logic pcm_ready = 1'b0;
  logic signed [15:0] pcm_l, pcm_r;
  logic pcm_valid, overrun, locked;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 sys_clk = ~sys_clk;
  ym3012_rx #(.SYNC_STAGES(2), .TIMEOUT(1024)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .so_clk(so_clk), .so(so),
    .sh1(sh1), .sh2(sh2), .pcm_l(pcm_l), .pcm_r(pcm_r), .pcm_valid(pcm_valid),
    .pcm_ready(pcm_ready), .overrun(overrun), .locked(locked)
  );
  function automatic logic [12:0] w(input logic [9:0] m, input logic [2:0] e);
    return {e, m};
  endfunction
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic clks(input int n);
    repeat (n) @(negedge sys_clk);
  endtask
  task automatic send(input logic [12:0] d, input int n);
    for (int b = 0; b < n; b++) begin
      so = d[b];
      clks(4);
      so_clk = 1'b1;
      clks(4);
      so_clk = 1'b0;
    end
  endtask
  task automatic strobe(input bit right);
    if (right) sh2 = 1'b0;
    else sh1 = 1'b0;
    clks(6);
    sh1 = 1'b1;
    sh2 = 1'b1;
    clks(4);
  endtask
  task automatic frame(input logic [12:0] l, input logic [12:0] r);
    send(l, 13);
    strobe(1'b0);
    send(r, 13);
    strobe(1'b1);
    clks(2);
  endtask
  task automatic ack();
    pcm_ready = 1'b1;
    clks(1);
    pcm_ready = 1'b0;
  endtask
  initial begin
    clks(3);
    chk("rst_valid", 16'(pcm_valid), 16'h0);
    chk("rst_l", pcm_l, 16'h0);
    chk("rst_locked", 16'(locked), 16'h0);
    chk("rst_overrun", 16'(overrun), 16'h0);
    sys_rst_n = 1'b1;
    clks(3);
    frame(w(10'h3FF, 3'd7), w(10'h000, 3'd7));
    chk("align_valid", 16'(pcm_valid), 16'h0);
    chk("align_locked", 16'(locked), 16'h0);
    frame(w(10'h3FF, 3'd7), w(10'h000, 3'd7));
    chk("max_l", pcm_l, 16'h7FC0);
    chk("min_r", pcm_r, 16'h8000);
    chk("first_valid", 16'(pcm_valid), 16'h1);
    chk("first_locked", 16'(locked), 16'h1);
    ack();
    chk("ack_valid", 16'(pcm_valid), 16'h0);
    frame(w(10'h201, 3'd1), w(10'h1FF, 3'd3));
    chk("one_l", pcm_l, 16'h0001);
    chk("neg4_r", pcm_r, 16'hFFFC);
    ack();
    frame(w(10'h123, 3'd0), w(10'h3FF, 3'd0));
    chk("e0_l", pcm_l, 16'h0);
    chk("e0_r", pcm_r, 16'h0);
    chk("e0_valid", 16'(pcm_valid), 16'h1);
    ack();
    frame(w(10'h201, 3'd1), w(10'h000, 3'd7));
    frame(w(10'h123, 3'd0), w(10'h3FF, 3'd0));
    chk("ovr_l", pcm_l, 16'h0001);
    chk("ovr_r", pcm_r, 16'h8000);
    chk("ovr_flag", 16'(overrun), 16'h1);
    chk("ovr_valid", 16'(pcm_valid), 16'h1);
    ack();
    chk("ovr_ack_valid", 16'(pcm_valid), 16'h0);
    frame(w(10'h1FF, 3'd3), w(10'h3FF, 3'd7));
    chk("post_ovr_l", pcm_l, 16'hFFFC);
    chk("post_ovr_r", pcm_r, 16'h7FC0);
    ack();
    send(w(10'h3FF, 3'd7), 12);
    strobe(1'b0);
    send(w(10'h000, 3'd7), 13);
    strobe(1'b1);
    clks(2);
    chk("short_valid", 16'(pcm_valid), 16'h0);
    frame(w(10'h000, 3'd7), w(10'h201, 3'd1));
    chk("short_next_l", pcm_l, 16'h8000);
    chk("short_next_r", pcm_r, 16'h0001);
    chk("short_next_valid", 16'(pcm_valid), 16'h1);
    clks(1100);
    chk("to_locked", 16'(locked), 16'h0);
    chk("to_valid", 16'(pcm_valid), 16'h1);
    chk("to_l", pcm_l, 16'h8000);
    ack();
    frame(w(10'h3FF, 3'd7), w(10'h3FF, 3'd7));
    chk("lost_valid", 16'(pcm_valid), 16'h0);
    chk("lost_locked", 16'(locked), 16'h0);
    frame(w(10'h201, 3'd1), w(10'h1FF, 3'd3));
    chk("resume_l", pcm_l, 16'h0001);
    chk("resume_r", pcm_r, 16'hFFFC);
    chk("resume_locked", 16'(locked), 16'h1);
    chk("resume_valid", 16'(pcm_valid), 16'h1);
    send(w(10'h3FF, 3'd7), 5);
    #3;
    sys_rst_n = 1'b0;
    #1;
    chk("arst_l", pcm_l, 16'h0);
    chk("arst_r", pcm_r, 16'h0);
    chk("arst_valid", 16'(pcm_valid), 16'h0);
    chk("arst_overrun", 16'(overrun), 16'h0);
    chk("arst_locked", 16'(locked), 16'h0);
    clks(2);
    sys_rst_n = 1'b1;
    clks(3);
    frame(w(10'h3FF, 3'd7), w(10'h000, 3'd7));
    chk("relock_align_valid", 16'(pcm_valid), 16'h0);
    frame(w(10'h3FF, 3'd7), w(10'h000, 3'd7));
    chk("relock_l", pcm_l, 16'h7FC0);
    chk("relock_r", pcm_r, 16'h8000);
    chk("relock_locked", 16'(locked), 16'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ym3012_rx.md
Name: ym3012_rx

Overview:
Serial DAC-interface receiver, the listening end of the YM2151-style serial audio link driven by the FM core (serial data, bit clock, SH1/SH2 sample-hold strobes).
- Oversamples the link in the sys_clk domain, deserializes 13-bit floating-point words and decodes them to 16-bit two's-complement PCM.
- Presents left/right samples to the sigma-delta modulators behind audio_a0/audio_a1 over a valid/ready handshake.

Parameters:
SYNC_STAGES, 2, flops in each input synchronizer (min 2).
TIMEOUT, 1024, sys_clk cycles with no bit-clock edge before the receiver drops sync.

Ports:
sys_clk  in  1  system clock (32 MHz); all logic on its rising edge.
sys_rst_n  in  1  asynchronous active-low reset, deasserted synchronously externally.
so_clk  in  1  serial bit clock from FM core (async, ≤ sys_clk/4).
so  in  1  serial data, LSB first, sampled on so_clk rising edge.
sh1  in  1  left sample-hold strobe; falling edge latches left word.
sh2  in  1  right sample-hold strobe; falling edge latches right word.
pcm_l  out  16  decoded left sample, signed.
pcm_r  out  16  decoded right sample, signed.
pcm_valid  out  1  sample pair available.
pcm_ready  in  1  consumer accepts pair when valid & ready.
overrun  out  1  sticky: a new pair was completed while the previous one was still unaccepted.
locked  out  1  receiver is aligned to strobes.

Behaviour:
- Reset: pcm_l=0, pcm_r=0, pcm_valid=0, overrun=0, locked=0, shift register and bit count cleared, FSM=HUNT.
- Inputs: each passes SYNC_STAGES flops, then a one-flop edge detector. Edge events are one sys_clk pulse, occurring SYNC_STAGES+1 cycles after the pin edge.
- Shift register: 13 bits. On so_clk rise event, the new bit enters at bit 12 and shifts right, so after 13 bits the first-received bit is at bit 0.
- Bit count: increments and saturates at 13.
- Word format: bits[9:0] mantissa m, offset binary; bits[12:10] exponent e.
- Decode (combinational from shift register):
  - s = {~m[9], m[8:0]} as signed 10-bit.
  - e=0 -> 0.
  - e=1..7 -> s sign-extended to 16 bits, shifted left by (e-1).
  - Max 511<<6 = 32704; min -512<<6 = -32768; no overflow.
- FSM:
  - HUNT: ignore data. On any SH1/SH2 falling event -> clear bit count, go SYNC.
  - SYNC: on SH1 fall with count=13 -> left holding reg <= decode, clear count, go GOT_L. SH2 fall, or count<13 at a strobe -> clear count, stay SYNC.
  - GOT_L: on SH2 fall with count=13 -> right holding <= decode, publish pair, locked=1, clear count, go SYNC. SH1 fall -> reload left holding if count=13, else back to SYNC. count<13 at SH2 -> SYNC, no publish.
- Publish:
  - pcm_valid=0 or handshake this cycle: pcm_l/pcm_r <= holding regs, pcm_valid <= 1.
  - Otherwise: overrun <= 1, new pair dropped, outputs unchanged.
- Handshake:
  - pcm_valid deasserts the cycle after valid&ready unless a publish coincides. A coinciding publish loads the new pair and keeps valid=1.
  - Outputs are stable while valid & !ready.
- Simultaneous events in one cycle:
  - so_clk rise coincident with a strobe fall: the strobe is processed on the pre-shift register, then the shift is applied and count=1.
  - SH1 and SH2 falling together: treated as protocol error -> SYNC, count cleared.
- Timeout: counter reset by every so_clk rise event. Reaching TIMEOUT -> locked=0, FSM=HUNT, pcm_valid unaffected.
- overrun clears only on reset.
- Reset mid-word or mid-handshake discards all state immediately.

Decomposition:
- Shared package ym_audio_pkg:
  - FSM state enum (HUNT, SYNC, GOT_L).
  - Constants WORD_BITS=13, MANT_BITS=10, EXP_BITS=3, PCM_WIDTH=16.
  - Decode function ym_fp_to_pcm.
- One natural sub-module: ym_sync_edge (synchronizer + rise/fall pulses), instantiated four times.

Test Plan:
- Reset, then frame L word m=0x3FF,e=7 and R word m=0x000,e=7 with SH1 then SH2 falling -> first pair discarded as HUNT/align. Second identical frame -> pcm_l=0x7FC0 (32704), pcm_r=0x8000, pcm_valid=1, locked=1.
- Word m=0x201,e=1 -> 1; m=0x1FF,e=3 -> -4; e=0 any m -> 0.
- Hold pcm_ready=0 across two complete frames -> first pair held unchanged, overrun=1. Assert ready -> valid drops next cycle. Next frame publishes normally.
- Only 12 bits clocked before SH1 falls -> no publish, FSM stays SYNC. Following full frame publishes correctly.
- Stop so_clk for TIMEOUT+10 cycles -> locked=0. Resume: one frame lost, the next frame publishes.
- Assert sys_rst_n low mid-word while pcm_valid=1 -> all outputs 0 immediately (asynchronous). Receiver re-locks after reset per the first scenario.
